// File: rtl/bin_to_bcd_16.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble).
// One conversion takes 32 cycles after the init-accepting edge; bcd holds the last result.
//
// state | meaning
// IDLE  | waiting for init after reset
// ADD   | add 3 to every BCD digit that is 5 or more
// SHIFT | shift the working register left by one bit
// DONE  | result valid in bcd; init starts the next conversion
module bin_to_bcd_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [35:0] a_q, a_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Digits never exceed 9 after a shift, so each correction stays within its nibble.
  function automatic logic [19:0] add3_digits(input logic [19:0] d);
    logic [19:0] r;
    r = d;
    for (int i = 0; i < 5; i++) begin
      if (d[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (init) begin
          a_d     = {20'd0, bin};
          cnt_d   = 5'd16;
          state_d = ADD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ADD: begin
        a_d     = {add3_digits(a_q[35:16]), a_q[15:0]};
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d   = {a_q[34:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
          bcd_d   = a_q[34:15];
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ADD;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
